// File: rtl/mdu_param.sv
// rtl/mdu_param.sv - HI/LO multiply/divide unit: pipelined-latency multiply/accumulate,
// iterative restoring divide with sign fix, mthi/mtlo moves and mfhi/mflo read port.
module mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             dbz
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = 7;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              dbz_q, dbz_d;

  logic              accept;
  logic              is_signed;
  logic [W2-1:0]     ext_a, ext_b, product, hilo;
  logic              neg_a, neg_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    shifted, diff;

  always_comb begin
    accept    = start && !req && !clr && (state_q == IDLE);
    is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    ext_a     = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    ext_b     = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    product   = ext_a * ext_b;
    hilo      = {hi_q, lo_q};
    neg_a     = is_signed && src_a[WIDTH-1];
    neg_b     = is_signed && src_b[WIDTH-1];
    mag_a     = neg_a ? -src_a : src_a;
    mag_b     = neg_b ? -src_b : src_b;
    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    shifted   = {rem_q, quo_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    dbz_d   = 1'b0;

    if (clr) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                if (op == OP_MADD || op == OP_MADDU)      acc_d = hilo + product;
                else if (op == OP_MSUB || op == OP_MSUBU) acc_d = hilo - product;
                else                                      acc_d = product;
                cnt_d   = MUL_CNT;
                state_d = MUL;
                busy_d  = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                busy_d = 1'b1;
                if (src_b == '0) begin
                  // Skip iteration; FIX then publishes {src_a, all ones} unmodified.
                  rem_d   = src_a;
                  quo_d   = '1;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  dz_d    = 1'b1;
                  state_d = FIX;
                end else begin
                  rem_d   = '0;
                  quo_d   = mag_a;
                  dvs_d   = mag_b;
                  qneg_d  = neg_a ^ neg_b;
                  rneg_d  = neg_a;
                  dz_d    = 1'b0;
                  cnt_d   = DIV_CNT;
                  state_d = DIV;
                end
              end
              OP_MTHI: hi_d = src_a;
              OP_MTLO: lo_d = src_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            {hi_d, lo_d} = acc_q;
            state_d      = IDLE;
            busy_d       = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
        FIX: begin
          // Most-negative / -1 falls out naturally: magnitude quotient negates back to itself.
          hi_d    = rneg_q ? -rem_q : rem_q;
          lo_d    = qneg_q ? -quo_q : quo_q;
          dbz_d   = dz_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    case (op)
      OP_MFHI: rd_data = hi_q;
      OP_MFLO: rd_data = lo_q;
      default: rd_data = '0;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_mdu_param.sv
// tb/tb_mdu_param.sv - self-checking bench for mdu_param: cycle-level architectural model
// compared every cycle, plus directed vectors with hand-computed literal results.
module tb_mdu_param;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic [W-1:0]  hi, lo, rd_data;
  logic          busy, dbz;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mdu_param #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .clr(clr), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo), .rd_data(rd_data),
    .busy(busy), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Architectural model: an op is a pending result plus a cycles-remaining count.
  logic [W-1:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit            m_dbz = 1'b0, p_dz = 1'b0;
  int            m_left = 0;

  always @(posedge clk) begin
    logic signed [63:0] sa, sb;
    logic [63:0]        prod, res;
    int                 q, r;
    m_dbz = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (clr) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_dbz = p_dz;
      end
    end else if (start && !req) begin
      sa = {{32{src_a[31]}}, src_a};
      sb = {{32{src_b[31]}}, src_b};
      if (op inside {4'd1, 4'd5, 4'd7}) prod = sa * sb;
      else prod = {32'd0, src_a} * {32'd0, src_b};
      p_dz = 1'b0;
      case (op)
        4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: begin
          if (op == 4'd5 || op == 4'd6)      res = {m_hi, m_lo} + prod;
          else if (op == 4'd7 || op == 4'd8) res = {m_hi, m_lo} - prod;
          else                               res = prod;
          {p_hi, p_lo} = res;
          m_left = LAT;
        end
        4'd3, 4'd4: begin
          if (src_b == 0) begin
            p_hi = src_a; p_lo = '1; p_dz = 1'b1; m_left = 1;
          end else begin
            if (op == 4'd3 && src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
              p_lo = 32'h8000_0000; p_hi = 0;
            end else if (op == 4'd3) begin
              q = $signed(src_a) / $signed(src_b);
              r = $signed(src_a) % $signed(src_b);
              p_lo = q; p_hi = r;
            end else begin
              p_lo = src_a / src_b; p_hi = src_a % src_b;
            end
            m_left = W + 1;
          end
        end
        4'd9:  m_hi = src_a;
        4'd10: m_lo = src_a;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_busy", busy, m_left > 0);
      check("cyc_dbz", dbz, m_dbz);
      check("cyc_rd", rd_data, (op == 4'd11) ? m_hi : (op == 4'd12) ? m_lo : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    cyc();
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic run(input string name, input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int lat, input logic [W-1:0] eh,
                     input logic [W-1:0] el);
    int n;
    issue(o, a, b);
    wait_idle(n);
    check({name, "_lat"}, n, lat);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) cyc();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_dbz", dbz, 0);
    reset = 1'b0;
    cyc();

    run("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_7_2", 4'd4, 32'd7, 32'd2, 33, 32'd1, 32'd3);
    run("div_7_m2", 4'd3, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run("div_m7_m2", 4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFF, 32'd3);
    run("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1);

    run("divu_dbz", 4'd4, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFF_FFFF);
    check("dbz_pulse", dbz, 1);
    cyc();
    check("dbz_clear", dbz, 0);

    run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

    issue(4'd9, 32'd0, 32'd0);
    check("mthi_busy", busy, 0);
    issue(4'd10, 32'd10, 32'd0);
    check("mtlo_busy", busy, 0);
    check("mtlo_lo", lo, 32'd10);
    run("madd", 4'd5, 32'd3, 32'd4, 5, 32'd0, 32'd22);
    run("msubu", 4'd8, 32'd5, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op = 4'd11; cyc();
    check("mfhi", rd_data, 32'hFFFF_FFFF);
    op = 4'd12; cyc();
    check("mflo", rd_data, 32'hFFFF_FFFD);
    op = 4'd0;

    issue(4'd3, 32'd100, 32'd7);
    repeat (9) cyc();
    check("clr_pre_busy", busy, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_hi", hi, 32'hFFFF_FFFF);
    check("clr_lo", lo, 32'hFFFF_FFFD);
    check("clr_dbz", dbz, 0);

    req = 1'b1;
    issue(4'd1, 32'd9, 32'd9);
    req = 1'b0;
    check("req_busy", busy, 0);
    cyc();
    check("req_lo", lo, 32'hFFFF_FFFD);

    issue(4'd13, 32'd1, 32'd1);
    check("rsvd_busy", busy, 0);

    issue(4'd1, 32'd6, 32'd7);
    start = 1'b1; op = 4'd9; src_a = 32'hDEAD_BEEF; src_b = 32'h1111_1111;
    cyc();
    src_a = 32'h0BAD_F00D; src_b = 32'h2222_2222;
    cyc();
    start = 1'b0; op = 4'd0;
    wait_idle(n);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd42);

    issue(4'd1, 32'd2, 32'd3);
    repeat (4) cyc();
    start = 1'b1; op = 4'd10; src_a = 32'h55;
    cyc();
    check("coinc_lo", lo, 32'd6);
    check("coinc_busy", busy, 0);
    cyc();
    start = 1'b0; op = 4'd0;
    check("after_lo", lo, 32'h55);
    check("after_hi", hi, 32'd0);

    reset = 1'b1; start = 1'b1; op = 4'd9; src_a = 32'h77;
    cyc();
    reset = 1'b0; start = 1'b0; op = 4'd0;
    check("rst2_hi", hi, 0);
    check("rst2_lo", lo, 0);
    cyc();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
